// File: rtl/md_force_engine.sv
// Lennard-Jones force sweep over all atoms: 8 cycles per neighbour plus ATOM and EMIT per atom.
// One result per atom on a valid/ready port; EMIT holds its outputs until out_ready is sampled high.
module md_force_engine #(
   parameter int N_ATOMS  = 32,
   parameter int MAX_NEI  = 4,
   parameter int DW       = 16,
   parameter int FRAC     = 8,
   parameter int BOX      = 32,
   parameter int R2_DEPTH = 64,
   parameter int LJ1      = 384,
   parameter int LJ2      = 512,
   localparam int AIW = $clog2(N_ATOMS),
   localparam int NLW = $clog2(N_ATOMS*MAX_NEI),
   localparam int CNW = $clog2(MAX_NEI+1),
   localparam int CW  = $clog2(BOX),
   localparam int LW  = $clog2(R2_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   input  logic                 pos_we,
   input  logic [AIW-1:0]       pos_waddr,
   input  logic [CW-1:0]        pos_wx,
   input  logic [CW-1:0]        pos_wy,
   input  logic [CW-1:0]        pos_wz,
   input  logic                 nl_we,
   input  logic [NLW-1:0]       nl_waddr,
   input  logic [AIW-1:0]       nl_wdata,
   input  logic                 cnt_we,
   input  logic [AIW-1:0]       cnt_waddr,
   input  logic [CNW-1:0]       cnt_wdata,
   input  logic                 lut_we,
   input  logic [LW-1:0]        lut_waddr,
   input  logic signed [DW-1:0] lut_wdata,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [AIW-1:0]       out_addr,
   output logic signed [DW-1:0] out_fx,
   output logic signed [DW-1:0] out_fy,
   output logic signed [DW-1:0] out_fz
);

   // One spare bit of headroom so +/-BOX is representable during the wrap.
   localparam int DXW = CW + 2;
   localparam int R2W = 2 * DXW;
   localparam logic signed [DXW-1:0] BOXS = DXW'(BOX);
   localparam logic signed [DXW-1:0] HALF = DXW'(BOX / 2);
   localparam logic signed [DW-1:0]  LJ1Q = DW'(LJ1);
   localparam logic signed [DW-1:0]  LJ2Q = DW'(LJ2);
   localparam logic signed [2*DW-1:0] RND = {{(2*DW-FRAC){1'b0}}, {FRAC{1'b1}}};
   localparam logic [CNW-1:0] MAXC = CNW'(MAX_NEI);

   typedef enum logic [3:0] {
      S_IDLE, S_ATOM, S_DIST, S_LUT, S_MUL1, S_MUL2, S_MUL3, S_MUL4, S_MUL5,
      S_ACC, S_EMIT, S_DONE
   } state_t;

   state_t state;

   logic [CW-1:0]        pos_x [N_ATOMS];
   logic [CW-1:0]        pos_y [N_ATOMS];
   logic [CW-1:0]        pos_z [N_ATOMS];
   logic [AIW-1:0]       nl_mem [N_ATOMS*MAX_NEI];
   logic [CNW-1:0]       cnt_mem [N_ATOMS];
   logic signed [DW-1:0] lut_mem [R2_DEPTH];

   logic [AIW-1:0]       i;
   logic [CNW-1:0]       j, cnt;
   logic signed [DW-1:0] dx_q, dy_q, dz_q;
   logic [R2W-1:0]       r2_q;
   logic signed [DW-1:0] r2inv, t1, r6, lj, pot, f_q;
   logic signed [DW-1:0] acc_x, acc_y, acc_z;

   function automatic logic signed [DW-1:0] mulq(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
      logic signed [2*DW-1:0] p;
      logic signed [2*DW-1:0] q;
      p = $signed({{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b});
      // Bias negative products so the arithmetic shift truncates toward zero.
      if (p < 0) p = p + RND;
      q = p >>> FRAC;
      return q[DW-1:0];
   endfunction

   function automatic logic signed [DXW-1:0] min_image(input logic [CW-1:0] a,
                                                       input logic [CW-1:0] b);
      logic signed [DXW-1:0] d;
      d = $signed({2'b00, a}) - $signed({2'b00, b});
      if (d > HALF)       d = d - BOXS;
      else if (d < -HALF) d = d + BOXS;
      return d;
   endfunction

   function automatic logic [R2W-1:0] sq(input logic signed [DXW-1:0] d);
      logic signed [R2W-1:0] e;
      e = R2W'(d);
      return $unsigned(e * e);
   endfunction

   logic [NLW-1:0]        nl_idx;
   logic [AIW-1:0]        k;
   logic signed [DXW-1:0] dx_w, dy_w, dz_w;
   logic [R2W-1:0]        r2_w;
   logic signed [DW-1:0]  acc_x_nx, acc_y_nx, acc_z_nx;

   assign nl_idx   = NLW'(i) * NLW'(MAX_NEI) + NLW'(j);
   assign k        = nl_mem[nl_idx];
   assign dx_w     = min_image(pos_x[i], pos_x[k]);
   assign dy_w     = min_image(pos_y[i], pos_y[k]);
   assign dz_w     = min_image(pos_z[i], pos_z[k]);
   assign r2_w     = sq(dx_w) + sq(dy_w) + sq(dz_w);
   assign acc_x_nx = acc_x + mulq(dx_q, f_q);
   assign acc_y_nx = acc_y + mulq(dy_q, f_q);
   assign acc_z_nx = acc_z + mulq(dz_q, f_q);

   // Host tables are only writable between sweeps.
   always_ff @(posedge clk) begin
      if (!busy) begin
         if (pos_we) begin
            pos_x[pos_waddr] <= pos_wx;
            pos_y[pos_waddr] <= pos_wy;
            pos_z[pos_waddr] <= pos_wz;
         end
         if (nl_we)  nl_mem[nl_waddr]   <= nl_wdata;
         if (cnt_we) cnt_mem[cnt_waddr] <= cnt_wdata;
         if (lut_we) lut_mem[lut_waddr] <= lut_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_fx    <= '0;
         out_fy    <= '0;
         out_fz    <= '0;
         i         <= '0;
         j         <= '0;
         cnt       <= '0;
         dx_q      <= '0;
         dy_q      <= '0;
         dz_q      <= '0;
         r2_q      <= '0;
         r2inv     <= '0;
         t1        <= '0;
         r6        <= '0;
         lj        <= '0;
         pot       <= '0;
         f_q       <= '0;
         acc_x     <= '0;
         acc_y     <= '0;
         acc_z     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  i     <= '0;
                  busy  <= 1'b1;
                  state <= S_ATOM;
               end
            end
            S_ATOM: begin
               acc_x <= '0;
               acc_y <= '0;
               acc_z <= '0;
               j     <= '0;
               cnt   <= (cnt_mem[i] > MAXC) ? MAXC : cnt_mem[i];
               if (cnt_mem[i] == '0) begin
                  out_valid <= 1'b1;
                  out_addr  <= i;
                  out_fx    <= '0;
                  out_fy    <= '0;
                  out_fz    <= '0;
                  state     <= S_EMIT;
               end else begin
                  state <= S_DIST;
               end
            end
            S_DIST: begin
               dx_q  <= DW'(dx_w) <<< FRAC;
               dy_q  <= DW'(dy_w) <<< FRAC;
               dz_q  <= DW'(dz_w) <<< FRAC;
               r2_q  <= r2_w;
               state <= S_LUT;
            end
            S_LUT: begin
               // r2 of zero (self or coincident atom) and anything past the table are cut off.
               r2inv <= (r2_q == '0 || r2_q >= R2W'(R2_DEPTH)) ? '0 : lut_mem[r2_q[LW-1:0]];
               state <= S_MUL1;
            end
            S_MUL1: begin t1  <= mulq(r2inv, r2inv);    state <= S_MUL2; end
            S_MUL2: begin r6  <= mulq(t1, r2inv);       state <= S_MUL3; end
            S_MUL3: begin lj  <= mulq(LJ1Q, r6);        state <= S_MUL4; end
            S_MUL4: begin pot <= mulq(r6, lj - LJ2Q);   state <= S_MUL5; end
            S_MUL5: begin f_q <= mulq(r2inv, pot);      state <= S_ACC;  end
            S_ACC: begin
               acc_x <= acc_x_nx;
               acc_y <= acc_y_nx;
               acc_z <= acc_z_nx;
               if (j + CNW'(1) == cnt) begin
                  out_valid <= 1'b1;
                  out_addr  <= i;
                  out_fx    <= acc_x_nx;
                  out_fy    <= acc_y_nx;
                  out_fz    <= acc_z_nx;
                  state     <= S_EMIT;
               end else begin
                  j     <= j + CNW'(1);
                  state <= S_DIST;
               end
            end
            S_EMIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (i == AIW'(N_ATOMS - 1)) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     i     <= i + AIW'(1);
                     state <= S_ATOM;
                  end
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_force_engine.sv
// Directed bench for md_force_engine: integer reference model of the LJ sweep plus literal anchors.
module tb_md_force_engine;

   localparam int N  = 32;
   localparam int MN = 4;

   logic              clk = 1'b0;
   logic              rst, start, busy, done;
   logic              pos_we, nl_we, cnt_we, lut_we;
   logic [4:0]        pos_waddr, cnt_waddr, nl_wdata, out_addr;
   logic [4:0]        pos_wx, pos_wy, pos_wz;
   logic [6:0]        nl_waddr;
   logic [2:0]        cnt_wdata;
   logic [5:0]        lut_waddr;
   logic signed [15:0] lut_wdata;
   logic              out_valid, out_ready;
   logic signed [15:0] out_fx, out_fy, out_fz;

   always #5 clk = ~clk;

   md_force_engine dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .pos_we(pos_we), .pos_waddr(pos_waddr), .pos_wx(pos_wx), .pos_wy(pos_wy), .pos_wz(pos_wz),
      .nl_we(nl_we), .nl_waddr(nl_waddr), .nl_wdata(nl_wdata),
      .cnt_we(cnt_we), .cnt_waddr(cnt_waddr), .cnt_wdata(cnt_wdata),
      .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_fx(out_fx), .out_fy(out_fy), .out_fz(out_fz)
   );

   int vectors = 0;
   int miscompares = 0;

   int mpx [N], mpy [N], mpz [N];
   int mnl [N*MN];
   int mcnt [N];
   int mlut [64];
   int exp_fx [N], exp_fy [N], exp_fz [N];
   int got_fx [N], got_fy [N], got_fz [N];
   int xfers = 0;
   int exp_next = 0;

   logic              prev_valid = 1'b0, prev_ready = 1'b0;
   logic [4:0]        prev_addr = '0;
   logic signed [15:0] prev_fx = '0, prev_fy = '0, prev_fz = '0;

   task automatic check(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   function automatic int w16(input int x);
      shortint s;
      s = shortint'(x);
      return int'(s);
   endfunction

   // Fixed-point multiply: integer division truncates toward zero, then wrap to 16 bits.
   function automatic int mq(input int a, input int b);
      return w16((a * b) / 256);
   endfunction

   function automatic int wrapd(input int d);
      if (d > 16)  return d - 32;
      if (d < -16) return d + 32;
      return d;
   endfunction

   // Returns expected cycles from the start cycle to the done cycle (inclusive of done).
   function automatic int model_sweep();
      int lat;
      lat = 1;
      for (int a = 0; a < N; a++) begin
         int c, ax, ay, az;
         c  = (mcnt[a] > MN) ? MN : mcnt[a];
         ax = 0; ay = 0; az = 0;
         for (int n = 0; n < c; n++) begin
            int kk, dx, dy, dz, r2, inv, r6, lj, pot, f;
            kk  = mnl[a*MN + n];
            dx  = wrapd(mpx[a] - mpx[kk]);
            dy  = wrapd(mpy[a] - mpy[kk]);
            dz  = wrapd(mpz[a] - mpz[kk]);
            r2  = dx*dx + dy*dy + dz*dz;
            inv = (r2 == 0 || r2 >= 64) ? 0 : mlut[r2];
            r6  = mq(mq(inv, inv), inv);
            lj  = mq(384, r6);
            pot = mq(r6, w16(lj - 512));
            f   = mq(inv, pot);
            ax  = w16(ax + mq(dx * 256, f));
            ay  = w16(ay + mq(dy * 256, f));
            az  = w16(az + mq(dz * 256, f));
         end
         exp_fx[a] = ax; exp_fy[a] = ay; exp_fz[a] = az;
         lat += 2 + 8 * c;
      end
      return lat;
   endfunction

   // Output monitor: every handshake is compared to the model; stalled outputs must hold.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && prev_valid && !prev_ready) begin
            check("hold_addr", int'(out_addr), int'(prev_addr));
            check("hold_fx", int'(out_fx), int'(prev_fx));
            check("hold_fy", int'(out_fy), int'(prev_fy));
            check("hold_fz", int'(out_fz), int'(prev_fz));
         end
         if (out_valid && out_ready) begin
            check("out_addr", int'(out_addr), exp_next);
            check("out_fx", int'(out_fx), exp_fx[out_addr]);
            check("out_fy", int'(out_fy), exp_fy[out_addr]);
            check("out_fz", int'(out_fz), exp_fz[out_addr]);
            got_fx[out_addr] = int'(out_fx);
            got_fy[out_addr] = int'(out_fy);
            got_fz[out_addr] = int'(out_fz);
            xfers++;
            exp_next++;
         end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_addr  = out_addr;
      prev_fx    = out_fx;
      prev_fy    = out_fy;
      prev_fz    = out_fz;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wpos(input int a, input int x, input int y, input int z, input bit upd);
      pos_we = 1'b1; pos_waddr = 5'(a); pos_wx = 5'(x); pos_wy = 5'(y); pos_wz = 5'(z);
      tick();
      pos_we = 1'b0;
      if (upd) begin mpx[a] = x; mpy[a] = y; mpz[a] = z; end
   endtask

   task automatic wnl(input int a, input int v);
      nl_we = 1'b1; nl_waddr = 7'(a); nl_wdata = 5'(v);
      tick();
      nl_we = 1'b0;
      mnl[a] = v;
   endtask

   task automatic wcnt(input int a, input int v);
      cnt_we = 1'b1; cnt_waddr = 5'(a); cnt_wdata = 3'(v);
      tick();
      cnt_we = 1'b0;
      mcnt[a] = v;
   endtask

   task automatic wlut(input int a, input int v);
      lut_we = 1'b1; lut_waddr = 6'(a); lut_wdata = 16'(v);
      tick();
      lut_we = 1'b0;
      mlut[a] = v;
   endtask

   task automatic run_sweep(input int stall, output int cyc);
      int  lat_exp;
      bit  stalled;
      lat_exp  = model_sweep() + stall;
      xfers    = 0;
      exp_next = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      check("busy_after_start", int'(busy), 1);
      stalled = 1'b0;
      while (!done && cyc < 3000) begin
         if (stall > 0 && !stalled && out_valid) begin
            out_ready = 1'b0;
            repeat (stall) tick();
            out_ready = 1'b1;
            cyc += stall;
            stalled = 1'b1;
         end else begin
            tick();
            cyc++;
         end
      end
      check("latency", cyc, lat_exp);
      check("xfers", xfers, N);
      tick();
      check("busy_after_done", int'(busy), 0);
      check("done_single", int'(done), 0);
   endtask

   initial begin
      int cyc;
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      pos_we = 1'b0; nl_we = 1'b0; cnt_we = 1'b0; lut_we = 1'b0;
      pos_waddr = '0; pos_wx = '0; pos_wy = '0; pos_wz = '0;
      nl_waddr = '0; nl_wdata = '0; cnt_waddr = '0; cnt_wdata = '0;
      lut_waddr = '0; lut_wdata = '0;
      repeat (3) tick();
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_valid", int'(out_valid), 0);
      check("rst_addr", int'(out_addr), 0);
      check("rst_fx", int'(out_fx), 0);
      check("rst_fy", int'(out_fy), 0);
      check("rst_fz", int'(out_fz), 0);
      rst = 1'b0;
      tick();

      for (int a = 0; a < N; a++) begin wpos(a, 0, 0, 0, 1'b1); wcnt(a, 0); end
      for (int a = 0; a < N*MN; a++) wnl(a, 0);
      for (int a = 0; a < 64; a++) wlut(a, 0);

      // Basic pair along x.
      wlut(1, 256); wlut(4, 64);
      wpos(1, 1, 0, 0, 1'b1);
      wnl(0, 1); wnl(4, 0);
      wcnt(0, 1); wcnt(1, 1);
      run_sweep(0, cyc);
      check("A_latency_lit", cyc, 81);
      check("A_fx0_lit", got_fx[0], 128);
      check("A_fx1_lit", got_fx[1], -128);
      check("A_fy0_lit", got_fy[0], 0);

      // Reset in MUL3 of atom 0, with a position write attempted while busy.
      xfers = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      wpos(1, 9, 9, 9, 1'b0);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_busy", int'(busy), 0);
      check("midrst_valid", int'(out_valid), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_xfers", xfers, 0);
      run_sweep(0, cyc);
      check("B_fx0_lit", got_fx[0], 128);
      check("B_fx1_lit", got_fx[1], -128);

      // Periodic wrap with a 5-cycle stall on the first result.
      wpos(1, 31, 0, 0, 1'b1);
      run_sweep(5, cyc);
      check("C_latency_lit", cyc, 86);
      check("C_fx0_lit", got_fx[0], -128);
      check("C_fx1_lit", got_fx[1], 128);

      // y axis, cutoff at r2=64, self neighbour, count clamp 7 -> 4.
      wlut(0, 256);
      wpos(1, 0, 2, 0, 1'b1);
      wpos(2, 0, 0, 8, 1'b1);
      wnl(0, 1); wnl(1, 2); wnl(2, 0); wnl(3, 2);
      wnl(4, 0); wnl(5, 1); wnl(6, 1);
      wcnt(0, 7); wcnt(1, 0);
      run_sweep(0, cyc);
      check("D_latency_lit", cyc, 97);
      check("D_fy0_lit", got_fy[0], 2);
      check("D_fx0_lit", got_fx[0], 0);
      check("D_fz0_lit", got_fz[0], 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/md_force_engine.md
# md_force_engine

Parametrised 3-D Lennard-Jones force kernel, the successor to the 1-D fixed-size neighbour-list force block in the molecular-dynamics datapath. A host loads per-atom lattice positions, variable-length neighbour lists and an r²→1/r² lookup table. The block then sweeps all atoms and accumulates Fx/Fy/Fz in Q-format fixed point, using periodic minimum-image wrap and a distance cutoff. It streams one result per atom over a valid/ready port with backpressure.

## Interface
Parameters:
- N_ATOMS, 32, atom count (≥2); AIW = $clog2(N_ATOMS)
- MAX_NEI, 4, neighbour-list slots per atom; NL depth N_ATOMS*MAX_NEI; CNW = $clog2(MAX_NEI+1)
- DW, 16, signed fixed-point word width
- FRAC, 8, fraction bits
- BOX, 32, periodic box edge (power of two); CW = $clog2(BOX)
- R2_DEPTH, 64, r2inv LUT depth; index r2 ≥ R2_DEPTH is beyond the cutoff
- LJ1, 384, LJ2, 512, Q-format LJ constants (1.5, 2.0)

Ports:
- clk in 1: single clock
- rst in 1: reset, synchronous, active-high
- start in 1: begin a sweep; sampled only in IDLE
- busy out 1: high in every state except IDLE
- done out 1: one-cycle pulse at end of sweep
- pos_we in 1; pos_waddr in AIW; pos_wx/pos_wy/pos_wz in CW each: unsigned position write
- nl_we in 1; nl_waddr in $clog2(N_ATOMS*MAX_NEI); nl_wdata in AIW: neighbour index write; slot = i*MAX_NEI+j
- cnt_we in 1; cnt_waddr in AIW; cnt_wdata in CNW: neighbour count of an atom
- lut_we in 1; lut_waddr in $clog2(R2_DEPTH); lut_wdata in DW: r2inv value, Q-format
- out_valid out 1; out_ready in 1
- out_addr out AIW; out_fx/out_fy/out_fz out DW signed

## Operation
- Memories are read combinationally and are not cleared by reset. All four write ports are honoured only when busy=0; writes while busy are dropped.
- States: IDLE, ATOM, DIST, LUT, MUL1–MUL5, ACC, EMIT, DONE.
- IDLE: start=1 → ATOM with i=0.
- ATOM: clears the accumulators and sets j=0. Latches cnt = min(count[i], MAX_NEI). cnt=0 → EMIT; otherwise → DIST.
- DIST: k=nl[i*MAX_NEI+j]. d = pos[i] − pos[k] on each axis, signed. Minimum image: d > BOX/2 → d−BOX; d < −BOX/2 → d+BOX; ±BOX/2 unchanged. Computes r2 = dx²+dy²+dz² as an integer. Latches the deltas as d<<<FRAC.
- LUT: r2inv = 0 if r2==0 or r2 ≥ R2_DEPTH; otherwise lut[r2].
- mulq(a,b) = (a*b)/2^FRAC, truncated toward zero, then keep the low DW bits (wrap).
- MUL1: t1 = mulq(r2inv,r2inv).
- MUL2: r6 = mulq(t1,r2inv).
- MUL3: lj = mulq(LJ1,r6).
- MUL4: pot = mulq(r6, lj−LJ2).
- MUL5: f = mulq(r2inv,pot).
- ACC: each axis acc += mulq(delta,f), wrapping at DW bits. If j==cnt−1 → EMIT; otherwise j++ → DIST.
- EMIT: out_valid=1 with out_addr=i and out_f*=acc, all stable until out_ready=1 is sampled. On the handshake: if i==N_ATOMS−1 → DONE; otherwise i++ → ATOM.
- DONE: done=1 → IDLE.
- start asserted while busy is ignored. rst in any state → IDLE, counters cleared, no EMIT or done is produced.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_addr=0, out_fx/fy/fz=0.
- The start cycle is in IDLE. The next cycle is ATOM with busy=1.
- Per atom: 1 (ATOM) + 8·cnt + EMIT cycles; EMIT is 1 cycle when out_ready=1.
- With out_ready tied high, the sweep takes Σ(2+8·cnt_i) cycles after the start cycle, followed by 1 DONE cycle.
- out_* change only on entry to EMIT. They hold their last values afterwards; out_valid=0 outside EMIT.
- done pulses in the DONE cycle; busy falls the following cycle.

## Test plan
- Atom0 at (0,0,0), atom1 at (1,0,0), nl[0]=1, nl[4]=0, counts 1,1, all other counts 0, lut[1]=256 → atom0 fx=128, atom1 fx=−128, all fy/fz=0, all other atoms 0; 32 EMITs, then done after Σ(2+8·cnt)=80 cycles.
- Wrap: atom0 x=0, atom1 x=31, nl[0]=1, count0=1 → atom0 fx=−128.
- Axis y: atom0 y=0, atom1 y=2, lut[4]=64, nl[0]=1, count0=1 → atom0 fy=2, fx=fz=0.
- Cutoff and self: r2=64 (dz=8) and a neighbour equal to itself each give 0 contribution; count=7 is clamped to 4.
- Backpressure: out_ready low for 5 cycles during EMIT → out_valid stays high and out_addr/out_f* stay constant; exactly one transfer per atom.
- rst during MUL3 → next cycle busy=0 and out_valid=0, memories retained; new start reproduces the first scenario; writes during busy are not visible.
